// File: rtl/cla_pipe_adder_if.sv
// ============================================================================
// Module   : cla_pipe_adder_if
// Purpose  : Operand/result valid-ready bundle for the pipelined CLA add/sub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_blk_p;
    logic             out_blk_g;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_blk_p, out_blk_g
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_blk_p, out_blk_g
    );
endinterface

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : 2-stage pipelined carry-lookahead add/sub with valid/ready flow
//            control and block P/G outputs for cascading.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cla_pipe_adder_if.slave  bus
);
    localparam int NGRP = WIDTH / GROUP;

    logic             adv1, adv2;
    logic             s1_valid, s2_valid;
    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NGRP-1:0]  s1_px, s1_gx;
    logic             s1_c0, s1_a_msb, s1_b_msb;

    logic [WIDTH-1:0] b_eff, p_in, g_in;
    logic [NGRP-1:0]  px_in, gx_in;

    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt, ovf_nxt, blk_p_nxt, blk_g_nxt;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, blk_p_q, blk_g_q;

    assign adv2 = !s2_valid || bus.out_ready;
    assign adv1 = !s1_valid || adv2;

    assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign p_in  = bus.in_a ^ b_eff;
    assign g_in  = bus.in_a & b_eff;

    // Group propagate/generate, folded from the bottom bit of each group upward
    always_comb begin
        logic pacc, gacc;
        px_in = '0;
        gx_in = '0;
        for (int j = 0; j < NGRP; j++) begin
            pacc = 1'b1;
            gacc = 1'b0;
            for (int k = 0; k < GROUP; k++) begin
                gacc = g_in[j*GROUP+k] | (p_in[j*GROUP+k] & gacc);
                pacc = pacc & p_in[j*GROUP+k];
            end
            px_in[j] = pacc;
            gx_in[j] = gacc;
        end
    end

    always_comb begin
        logic [NGRP:0] gc;
        logic          c;
        logic          bg;
        sum_nxt = '0;
        gc[0]   = s1_c0;
        for (int j = 0; j < NGRP; j++) begin
            gc[j+1] = s1_gx[j] | (s1_px[j] & gc[j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            c = gc[j];
            for (int k = 0; k < GROUP; k++) begin
                sum_nxt[j*GROUP+k] = s1_p[j*GROUP+k] ^ c;
                c = s1_g[j*GROUP+k] | (s1_p[j*GROUP+k] & c);
            end
        end
        // Block generate ignores the incoming carry so cascaded trees stay carry-independent
        bg = 1'b0;
        for (int j = 0; j < NGRP; j++) begin
            bg = s1_gx[j] | (s1_px[j] & bg);
        end
        cout_nxt  = gc[NGRP];
        ovf_nxt   = (s1_a_msb == s1_b_msb) && (sum_nxt[WIDTH-1] != s1_a_msb);
        blk_p_nxt = &s1_px;
        blk_g_nxt = bg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_px    <= '0;
            s1_gx    <= '0;
            s1_c0    <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
            s2_valid <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            blk_p_q  <= 1'b0;
            blk_g_q  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= bus.in_valid;
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_px    <= px_in;
                s1_gx    <= gx_in;
                s1_c0    <= bus.in_sub | bus.in_cin;
                s1_a_msb <= bus.in_a[WIDTH-1];
                s1_b_msb <= b_eff[WIDTH-1];
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    sum_q   <= sum_nxt;
                    cout_q  <= cout_nxt;
                    ovf_q   <= ovf_nxt;
                    blk_p_q <= blk_p_nxt;
                    blk_g_q <= blk_g_nxt;
                end
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_blk_p = blk_p_q;
    assign bus.out_blk_g = blk_g_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// ============================================================================
// Module   : tb_cla_pipe_adder
// Purpose  : Self-checking bench: arithmetic reference model plus scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_pipe_adder;
    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int RW    = WIDTH + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] expq[$];
    logic [RW-1:0] dut_out;
    assign dut_out = {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_blk_p, bus.out_blk_g};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer add with the carry-in folded in; block generate is
    // the carry-out of the same sum taken with a zero carry-in.
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full, nocin;
        logic             c0, ovf;
        bb    = sub ? ~b : b;
        c0    = sub ? 1'b1 : cin;
        full  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
        nocin = {1'b0, a} + {1'b0, bb};
        ovf   = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {full[WIDTH-1:0], full[WIDTH], ovf, &(a ^ bb), nocin[WIDTH]};
    endfunction

    logic          prev_stall = 1'b0;
    logic [RW-1:0] prev_out;

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 32'({bus.out_valid, dut_out}), 32'({1'b1, prev_out}));
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got result 0x%0h required none at %0t", dut_out, $time);
                end else begin
                    check("result", 32'(dut_out), 32'(expq.pop_front()));
                end
            end
            if (bus.in_valid && bus.in_ready)
                expq.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = dut_out;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (expq.size() == 0) break;
        end
        check("drain_empty", 32'(expq.size()), 32'(0));
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, input logic [RW-1:0] exp);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_beat(a, b, cin, sub);
        @(negedge clk);
        check({name, "_early"}, 32'(bus.out_valid), 32'(0));
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.out_valid), 32'(1));
        check(name, 32'(dut_out), 32'(exp));
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        int  accepted;
        int  cycles;
        bit  acc;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.out_valid, dut_out}), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // {sum, cout, ovf, blk_p, blk_g}
        directed("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 4'b1001});
        directed("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b0100});
        directed("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 4'b0000});
        directed("sub_5_7",     16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 4'b0000});
        directed("sub_8000_1",  16'h8000, 16'h0001, 1'b1, 1'b1, {16'h7FFF, 4'b1101});
        directed("add_blk_p",   16'h00FF, 16'hFF00, 1'b1, 1'b0, {16'h0000, 4'b1010});

        // Back-to-back with a stalled consumer
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send_beat(16'h1111, 16'h2222, 1'b0, 1'b0);
        send_beat(16'hF000, 16'h0F00, 1'b1, 1'b0);
        @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready), 32'(0));
        fork
            begin
                send_beat(16'h0100, 16'h0200, 1'b0, 1'b1);
                send_beat(16'hABCD, 16'h1234, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send_beat(16'h4444, 16'h5555, 1'b0, 1'b0);
        send_beat(16'h6666, 16'h7777, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_async", 32'({bus.out_valid, dut_out}), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(bus.out_valid), 32'(0));
        end

        // Random traffic with random backpressure
        accepted = 0;
        cycles   = 0;
        acc      = 1'b0;
        @(posedge clk);
        #1;
        while (accepted < 3000 && cycles < 20000) begin
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 9) < 8);
                bus.in_a     = pick_operand();
                bus.in_b     = pick_operand();
                bus.in_cin   = 1'($urandom);
                bus.in_sub   = 1'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) accepted++;
            cycles++;
            @(posedge clk);
            #1;
        end
        check("random_accepted", 32'(accepted), 32'(3000));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Full throughput: one beat per cycle both in and out
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_a   = WIDTH'($urandom);
            bus.in_b   = WIDTH'($urandom);
            bus.in_cin = 1'($urandom);
            bus.in_sub = 1'($urandom);
            @(negedge clk);
            check("tput_in_ready", 32'(bus.in_ready), 32'(1));
            if (i >= 2) check("tput_out_valid", 32'(bus.out_valid), 32'(1));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
